// File: rtl/circuito_simple_pkg.sv
// -----------------------------------------------------------------------------
// circuito_simple_pkg
// Shared definitions for the circuito_simple gate-network slice:
//   - default values for the pipeline depth and the edge-counter width
//   - stage_t: the {valid, x, y} payload carried by every pipeline stage
//   - logic_fn(): the pure gate function {x, y} = {(a & b) | ~c, ~c}
// -----------------------------------------------------------------------------
package circuito_simple_pkg;

  localparam int DEF_PIPE_STAGES = 1;
  localparam int DEF_CNT_W       = 8;

  typedef struct packed {
    logic valid;
    logic x;
    logic y;
  } stage_t;

  // Returns {x, y} for one operand set.
  function automatic logic [1:0] logic_fn(input logic a, input logic b, input logic c);
    logic x;
    logic y;
    x = (a & b) | ~c;
    y = ~c;
    return {x, y};
  endfunction

endpackage

// File: rtl/circuito_simple_if.sv
// -----------------------------------------------------------------------------
// circuito_simple_if
// Operand/result bundle for circuito_simple.
//   in_valid, a, b, c : operand set and its qualifier (driven by the master)
//   out_valid, x, y   : result and its qualifier (driven by the block)
//   x_rise_cnt        : saturating count of valid 0->1 transitions of x
// Modports: master = the datapath feeding the block, slave = the block.
// -----------------------------------------------------------------------------
interface circuito_simple_if
  import circuito_simple_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             a;
  logic             b;
  logic             c;
  logic             out_valid;
  logic             x;
  logic             y;
  logic [CNT_W-1:0] x_rise_cnt;

  modport master (
    output in_valid, a, b, c,
    input  out_valid, x, y, x_rise_cnt
  );

  modport slave (
    input  in_valid, a, b, c,
    output out_valid, x, y, x_rise_cnt
  );

endinterface

// File: rtl/circuito_simple_stage.sv
// -----------------------------------------------------------------------------
// circuito_simple_stage
// One pipeline register carrying {valid, x, y}. Everything clears on reset so
// that in-flight operands are discarded and never produce an out_valid pulse.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   d_i    : stage input payload
//   q_o    : registered payload
// -----------------------------------------------------------------------------
module circuito_simple_stage
  import circuito_simple_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_q;

  // NOTE: the data bits are reset along with valid because x and y are
  // visible at the block outputs and must read 0 during reset; a pure
  // datapath register could skip its reset and keep only valid resettable.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's old value on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= d_i;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/circuito_simple.sv
// -----------------------------------------------------------------------------
// circuito_simple
// Registered gate network x = (a & b) | ~c, y = ~c with a PIPE_STAGES-deep
// pipeline (1..4) and a saturating counter of x rising edges.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : circuito_simple_if.slave (in_valid/a/b/c in,
//            out_valid/x/y/x_rise_cnt out)
// The function is evaluated ahead of stage 1; the pipeline only carries
// {valid, x, y}. Data loads every cycle; only valid decides whether a sample
// matters. The edge detector compares each valid x against the last valid x,
// so rising edges are detected across gaps in out_valid.
// -----------------------------------------------------------------------------
module circuito_simple
  import circuito_simple_pkg::*;
#(
  parameter int PIPE_STAGES = DEF_PIPE_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  circuito_simple_if.slave   bus
);

  stage_t head_d;
  stage_t pipe_q [PIPE_STAGES];
  stage_t tail;

  always_comb begin
    logic [1:0] xy;
    xy           = logic_fn(bus.a, bus.b, bus.c);
    head_d.valid = bus.in_valid;
    head_d.x     = xy[1];
    head_d.y     = xy[0];
  end

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      circuito_simple_stage u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (head_d),
        .q_o   (pipe_q[i])
      );
    end else begin : g_next
      circuito_simple_stage u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pipe_q[i-1]),
        .q_o   (pipe_q[i])
      );
    end
  end

  assign tail = pipe_q[PIPE_STAGES-1];

  // Edge detector and saturating counter.
  logic             last_x_q;
  logic             last_x_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: both next-state values get a hold default first so no path through
  // this block leaves them unassigned, which would infer a latch.
  always_comb begin
    last_x_d = last_x_q;
    cnt_d    = cnt_q;
    if (tail.valid) begin
      last_x_d = tail.x;
      if (tail.x && !last_x_q && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_x_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      last_x_q <= last_x_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.out_valid  = tail.valid;
  assign bus.x          = tail.x;
  assign bus.y          = tail.y;
  assign bus.x_rise_cnt = cnt_q;

endmodule

// File: tb/tb_circuito_simple.sv
// -----------------------------------------------------------------------------
// tb_circuito_simple
// Three instances share one stimulus stream:
//   dut1 : PIPE_STAGES=1, CNT_W=8
//   dut4 : PIPE_STAGES=4, CNT_W=8
//   dutc : PIPE_STAGES=1, CNT_W=2 (counter saturates at 3)
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_circuito_simple;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  circuito_simple_if #(.CNT_W(8)) if1 ();
  circuito_simple_if #(.CNT_W(8)) if4 ();
  circuito_simple_if #(.CNT_W(2)) ifc ();

  assign if1.in_valid = in_valid;
  assign if1.a = a;
  assign if1.b = b;
  assign if1.c = c;
  assign if4.in_valid = in_valid;
  assign if4.a = a;
  assign if4.b = b;
  assign if4.c = c;
  assign ifc.in_valid = in_valid;
  assign ifc.a = a;
  assign ifc.b = b;
  assign ifc.c = c;

  circuito_simple #(.PIPE_STAGES(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  circuito_simple #(.PIPE_STAGES(4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  circuito_simple #(.PIPE_STAGES(1), .CNT_W(2)) dutc (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-written truth table, index = {a, b, c}, value = {x, y}.
  function automatic logic [1:0] truth(input logic [2:0] abc);
    case (abc)
      3'b000:  return 2'b11;
      3'b001:  return 2'b00;
      3'b010:  return 2'b11;
      3'b011:  return 2'b00;
      3'b100:  return 2'b11;
      3'b101:  return 2'b00;
      3'b110:  return 2'b11;
      default: return 2'b10;  // 111
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] abc);
    in_valid = v;
    a = abc[2];
    b = abc[1];
    c = abc[0];
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       v;
    logic [2:0] abc;
    int         cnt1;  // x_rise_cnt of dut1 sampled after this step
    int         cntc;  // x_rise_cnt of dutc sampled after this step
  } step_t;

  step_t tbl [20];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // v, abc, cnt1, cntc
    tbl[0]  = '{1'b1, 3'b000, 0, 0};  // first valid x=1 after reset
    tbl[1]  = '{1'b1, 3'b111, 1, 1};  // continuous stream, x stays 1
    tbl[2]  = '{1'b1, 3'b101, 1, 1};  // x=0
    tbl[3]  = '{1'b0, 3'b000, 1, 1};  // 3-cycle gap
    tbl[4]  = '{1'b0, 3'b000, 1, 1};
    tbl[5]  = '{1'b0, 3'b000, 1, 1};
    tbl[6]  = '{1'b1, 3'b000, 1, 1};  // x=1 across the gap: rising edge
    tbl[7]  = '{1'b0, 3'b000, 2, 2};
    tbl[8]  = '{1'b1, 3'b000, 2, 2};  // all 8 combinations back-to-back
    tbl[9]  = '{1'b1, 3'b001, 2, 2};
    tbl[10] = '{1'b1, 3'b010, 2, 2};
    tbl[11] = '{1'b1, 3'b011, 3, 3};
    tbl[12] = '{1'b1, 3'b100, 3, 3};
    tbl[13] = '{1'b1, 3'b101, 4, 3};  // 2-bit counter saturated
    tbl[14] = '{1'b1, 3'b110, 4, 3};
    tbl[15] = '{1'b1, 3'b111, 5, 3};
    tbl[16] = '{1'b0, 3'b000, 5, 3};  // flush the 4-deep pipeline
    tbl[17] = '{1'b0, 3'b000, 5, 3};
    tbl[18] = '{1'b0, 3'b000, 5, 3};
    tbl[19] = '{1'b0, 3'b000, 5, 3};

    // Reset state.
    @(negedge clk);
    check("rst dut1 out_valid", 32'(if1.out_valid), 0);
    check("rst dut1 x", 32'(if1.x), 0);
    check("rst dut1 y", 32'(if1.y), 0);
    check("rst dut1 cnt", 32'(if1.x_rise_cnt), 0);
    check("rst dut4 out_valid", 32'(if4.out_valid), 0);
    check("rst dutc cnt", 32'(ifc.x_rise_cnt), 0);
    rst_n = 1'b1;

    // Directed table.
    for (int k = 0; k < 20; k++) begin
      int j;
      logic exp_v4;
      drive(tbl[k].v, tbl[k].abc);
      check($sformatf("s%0d dut1 out_valid", k), 32'(if1.out_valid), 32'(tbl[k].v));
      if (tbl[k].v) begin
        check($sformatf("s%0d dut1 x", k), 32'(if1.x), 32'(truth(tbl[k].abc)[1]));
        check($sformatf("s%0d dut1 y", k), 32'(if1.y), 32'(truth(tbl[k].abc)[0]));
      end
      check($sformatf("s%0d dut1 cnt", k), 32'(if1.x_rise_cnt), tbl[k].cnt1);
      check($sformatf("s%0d dutc cnt", k), 32'(ifc.x_rise_cnt), tbl[k].cntc);

      // dut4 shows the operands driven three steps earlier.
      j = k - 3;
      exp_v4 = (j >= 0) ? tbl[(j >= 0) ? j : 0].v : 1'b0;
      check($sformatf("s%0d dut4 out_valid", k), 32'(if4.out_valid), 32'(exp_v4));
      if (exp_v4) begin
        check($sformatf("s%0d dut4 x", k), 32'(if4.x), 32'(truth(tbl[j].abc)[1]));
        check($sformatf("s%0d dut4 y", k), 32'(if4.y), 32'(truth(tbl[j].abc)[0]));
      end
      check($sformatf("s%0d dut4 cnt", k), 32'(if4.x_rise_cnt),
            (j >= 0) ? tbl[(j >= 0) ? j : 0].cnt1 : 0);
    end

    // Reset with three operands in flight in dut4.
    drive(1'b1, 3'b000);
    drive(1'b1, 3'b000);
    drive(1'b1, 3'b000);
    check("pre-rst dut1 out_valid", 32'(if1.out_valid), 1);
    check("pre-rst dut1 cnt", 32'(if1.x_rise_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid-rst dut1 out_valid", 32'(if1.out_valid), 0);
    check("mid-rst dut1 x", 32'(if1.x), 0);
    check("mid-rst dut1 y", 32'(if1.y), 0);
    check("mid-rst dut1 cnt", 32'(if1.x_rise_cnt), 0);
    check("mid-rst dut4 out_valid", 32'(if4.out_valid), 0);
    check("mid-rst dut4 cnt", 32'(if4.x_rise_cnt), 0);
    check("mid-rst dutc cnt", 32'(ifc.x_rise_cnt), 0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // No stale result may appear after release.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 3'b000);
      check($sformatf("post-rst %0d dut4 out_valid", k), 32'(if4.out_valid), 0);
      check($sformatf("post-rst %0d dut1 out_valid", k), 32'(if1.out_valid), 0);
    end

    // First valid x=1 after reset counts as a rising edge.
    drive(1'b1, 3'b110);
    check("post-rst dut1 x", 32'(if1.x), 1);
    drive(1'b0, 3'b000);
    check("post-rst dut1 cnt", 32'(if1.x_rise_cnt), 1);
    check("post-rst dutc cnt", 32'(ifc.x_rise_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/circuito_simple.md
# circuito_simple

Registered implementation of the classic two-output gate network: x = (A AND B) OR (NOT C), y = NOT C. Three single-bit operands enter with a valid strobe, pass through a configurable pipeline, and leave with a matching valid strobe. The block also keeps a saturating count of x rising edges for status reporting. It is a leaf block used as a small combinational-logic slice inside larger datapaths.

## Interface

Parameters:
- PIPE_STAGES, default 1: register stages from input capture to output; legal range 1..4.
- CNT_W, default 8: width of the x rising-edge counter.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  qualifies a, b and c in the current cycle.
- a  input  1  operand A.
- b  input  1  operand B.
- c  input  1  operand C.
- out_valid  output  1  qualifies x and y.
- x  output  1  (a AND b) OR (NOT c).
- y  output  1  NOT c.
- x_rise_cnt  output  CNT_W  saturating count of valid 0->1 transitions of x.

## Operation

- The logic function is evaluated on the captured operands: x = (a & b) | ~c, y = ~c.
- Truth points:
  - a=b=c=0 gives x=1, y=1.
  - a=b=c=1 gives x=1, y=0.
  - a=1, b=0, c=1 gives x=0, y=0.
- in_valid propagates alongside the data through all stages and appears as out_valid.
- When in_valid=0, the stage-1 valid bit is 0.
  - Data registers load every cycle regardless of valid. No data gating is required.
  - x and y are don't-care while out_valid=0.
- Edge tracking:
  - A register last_x holds the x value of the most recent cycle with out_valid=1.
  - x_rise_cnt increments when out_valid=1, x=1 and last_x=0.
  - It saturates at 2^CNT_W−1 and never wraps.
- Cycles with out_valid=0 neither change last_x nor the counter.
  - A rising edge is therefore detected across valid gaps, comparing only against the last valid sample.
- There is no backpressure. The block accepts a new operand set every cycle.

## Timing

- Latency is exactly PIPE_STAGES clock cycles from a sampled in_valid=1 to out_valid=1 with the corresponding x and y.
- Throughput is one result per cycle.
- The counter updates on the same clock edge after the qualifying output is visible.
  - x_rise_cnt reflects a rising edge one cycle after out_valid=1, x=1 is presented.
- Reset values, applied asynchronously on rst_n low: all valid bits 0, out_valid 0, x 0, y 0, last_x 0, x_rise_cnt 0.
  - Reset release is synchronised by the clock. The first capture occurs on the first rising edge with rst_n=1.
- Reset mid-operation discards all in-flight operands. No out_valid pulse is produced for them.
- After reset, the first valid x=1 counts as a rising edge, because last_x resets to 0.

## Structure

- Package circuito_simple_pkg holds:
  - default constants for PIPE_STAGES and CNT_W;
  - the pure function computing {x, y} from {a, b, c}.
- Sub-module circuito_simple_stage: one register stage carrying {valid, x, y} with async active-low reset.
  - The top instantiates it PIPE_STAGES times via generate.
  - The logic function is evaluated before stage 1.
- The edge detector and saturating counter live in the top level.

## Test plan

- Reset then a=b=c=0, in_valid=1 -> after PIPE_STAGES cycles out_valid=1, x=1, y=1; x_rise_cnt=1 one cycle later.
- Continuous stream a=b=c=0, then a=b=c=1 on consecutive cycles -> outputs (x=1, y=1) then (x=1, y=0) in order; counter stays 1.
- Sequence a=1, b=0, c=1 then a=0, b=0, c=0, with a 3-cycle in_valid=0 gap between them -> x 0 then 1; counter increments once; no out_valid during the gap.
- All 8 input combinations back-to-back with PIPE_STAGES=1 and PIPE_STAGES=4 -> x, y match the truth function at the exact latency.
- CNT_W=2, alternating valid x=0/x=1 for 5 rising edges -> counter reads 1, 2, 3, 3, 3 (saturated).
- Assert rst_n low while 3 valid operands are in flight with PIPE_STAGES=4 -> out_valid, x, y and x_rise_cnt go to 0 immediately; no stale result appears after release.
